// File: rtl/alu_share_pkg.sv
// alu_share_pkg: shared widths and FSM state encoding for the ALU-sharing arbiter.
package alu_share_pkg;
    localparam int ALU_W = 4;
    localparam int OP_W  = 3;
    localparam int RES_W = 5;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/alu.sv
// alu: 4-bit combinational ALU, 5-bit result so carries and shifts keep their top bit.
module alu
    import alu_share_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [RES_W-1:0] result
);
    always_comb begin
        case (op)
            3'd0:    result = {1'b0, a} + {1'b0, b};
            3'd1:    result = {1'b0, a} - {1'b0, b};
            3'd2:    result = {1'b0, a & b};
            3'd3:    result = {1'b0, a | b};
            3'd4:    result = {1'b0, a ^ b};
            3'd5:    result = {a, 1'b0};
            3'd6:    result = {2'b00, a[ALU_W-1:1]};
            default: result = {1'b0, ~a};
        endcase
    end
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; ptr breaks the tie only when both request.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic       gnt,
    output logic       any
);
    assign any = |valid;
    assign gnt = &valid ? ptr : valid[1];
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two requesters through an
// IDLE -> ISSUE -> RESP FSM with a registered, tagged response channel.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter logic RR_INIT = 1'b0,
    parameter int   CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*ALU_W-1:0] req_a,
    input  logic [2*ALU_W-1:0] req_b,
    input  logic [2*OP_W-1:0]  req_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [RES_W-1:0]   rsp_result,
    output logic               busy,
    output logic [CNT_W-1:0]   op_cnt0,
    output logic [CNT_W-1:0]   op_cnt1
);
    state_t             state;
    logic               rr_ptr;
    logic               gnt;
    logic               any;
    logic               id_q;
    logic [ALU_W-1:0]   a_q;
    logic [ALU_W-1:0]   b_q;
    logic [OP_W-1:0]    op_q;
    logic [RES_W-1:0]   alu_res;

    rr_arb2 u_arb (.valid(req_valid), .ptr(rr_ptr), .gnt(gnt), .any(any));

    // The ALU only ever sees latched operands, so requester payload may change after accept.
    alu u_alu (.a(a_q), .b(b_q), .op(op_q), .result(alu_res));

    assign req_ready = (!rst && state == IDLE && any) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= RR_INIT;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            op_cnt0    <= '0;
            op_cnt1    <= '0;
            id_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    a_q    <= gnt ? req_a[2*ALU_W-1:ALU_W] : req_a[ALU_W-1:0];
                    b_q    <= gnt ? req_b[2*ALU_W-1:ALU_W] : req_b[ALU_W-1:0];
                    op_q   <= gnt ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
                    id_q   <= gnt;
                    rr_ptr <= ~gnt;
                    state  <= ISSUE;
                end
                ISSUE: begin
                    rsp_result <= alu_res;
                    rsp_id     <= id_q;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    // Increment by the inverted all-ones flag so counters stick at max.
                    if (rsp_id) op_cnt1 <= op_cnt1 + {{(CNT_W-1){1'b0}}, ~&op_cnt1};
                    else        op_cnt0 <= op_cnt0 + {{(CNT_W-1){1'b0}}, ~&op_cnt0};
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scenario tasks with randomized stimulus checked against
// a transaction-level model (grant order, ALU arithmetic, saturating counts).
module tb_alu_share_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [7:0] req_a = '0;
    logic [7:0] req_b = '0;
    logic [5:0] req_op = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_id;
    logic [4:0] rsp_result;
    logic       busy;
    logic [7:0] op_cnt0;
    logic [7:0] op_cnt1;

    int tests = 0;
    int fails = 0;
    int cnt_m [2];
    bit pri_m;

    alu_share_arbiter #(.RR_INIT(1'b0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .busy(busy), .op_cnt0(op_cnt0), .op_cnt1(op_cnt1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic logic [4:0] golden(input int a, input int b, input int op);
        int r;
        case (op)
            0: r = a + b;
            1: r = (a - b + 32) % 32;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a * 2;
            6: r = a / 2;
            default: r = 15 - a;
        endcase
        return 5'(r);
    endfunction

    task automatic model_done(input bit id);
        if (cnt_m[id] < 255) cnt_m[id]++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cnt_m = '{0, 0};
        pri_m = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready got %b want 00", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (rsp_id !== 1'b0 || rsp_result !== 5'd0) begin fails++; $display("FAIL reset_rsp got id=%b res=%0d want 0/0", rsp_id, rsp_result); end
        tests++; if (op_cnt0 !== 8'd0 || op_cnt1 !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", op_cnt0, op_cnt1); end
        rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        cnt_m = '{0, 0};
        pri_m = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_a[3:0] = 4'd5; req_b[3:0] = 4'd3; req_op[2:0] = 3'd0;
        req_valid = 2'b01; rsp_ready = 1'b1;
        #1;
        tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_ready got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        tests++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL single_issue got busy=%b rsp_valid=%b want 1/0", busy, rsp_valid); end
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== golden(5, 3, 0))
            begin fails++; $display("FAIL single_rsp got v=%b id=%b res=%0d want 1/0/%0d", rsp_valid, rsp_id, rsp_result, golden(5, 3, 0)); end
        model_done(1'b0);
        pri_m = 1'b1;
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_cnt0 !== 8'(cnt_m[0]))
            begin fails++; $display("FAIL single_done got v=%b busy=%b cnt0=%0d want 0/0/%0d", rsp_valid, busy, op_cnt0, cnt_m[0]); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_contention();
        bit exp;
        int ea;
        int eb;
        int eo;
        do_reset();
        req_a = 8'($urandom); req_b = 8'($urandom); req_op = 6'($urandom);
        req_valid = 2'b11; rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            exp = pri_m;
            ea = exp ? int'(req_a[7:4]) : int'(req_a[3:0]);
            eb = exp ? int'(req_b[7:4]) : int'(req_b[3:0]);
            eo = exp ? int'(req_op[5:3]) : int'(req_op[2:0]);
            tests++; if (req_ready !== (exp ? 2'b10 : 2'b01)) begin fails++; $display("FAIL contention_grant%0d got %b want %b", i, req_ready, exp ? 2'b10 : 2'b01); end
            repeat (2) @(negedge clk);
            tests++; if (rsp_valid !== 1'b1 || rsp_id !== exp || rsp_result !== golden(ea, eb, eo))
                begin fails++; $display("FAIL contention_rsp%0d got v=%b id=%b res=%0d want 1/%b/%0d", i, rsp_valid, rsp_id, rsp_result, exp, golden(ea, eb, eo)); end
            model_done(exp);
            pri_m = !exp;
            @(negedge clk);
            #1;
        end
        req_valid = 2'b00; rsp_ready = 1'b0;
        tests++; if (op_cnt0 !== 8'd4 || op_cnt1 !== 8'd4) begin fails++; $display("FAIL contention_cnt got %0d/%0d want 4/4", op_cnt0, op_cnt1); end
    endtask

    task automatic test_backpressure();
        logic [4:0] er;
        @(negedge clk);
        req_a[3:0] = 4'($urandom); req_b[3:0] = 4'($urandom); req_op[2:0] = 3'($urandom);
        er = golden(int'(req_a[3:0]), int'(req_b[3:0]), int'(req_op[2:0]));
        req_valid = 2'b01; rsp_ready = 1'b0;
        #1;
        tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL bp_ready got %b want 01", req_ready); end
        pri_m = 1'b1;
        @(negedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== er || req_ready !== 2'b00 || busy !== 1'b1)
                begin fails++; $display("FAIL bp_hold%0d got v=%b id=%b res=%0d rdy=%b busy=%b want 1/0/%0d/00/1", i, rsp_valid, rsp_id, rsp_result, req_ready, busy, er); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        model_done(1'b0);
        tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_next_accept got %b want 10", req_ready); end
        tests++; if (op_cnt0 !== 8'(cnt_m[0])) begin fails++; $display("FAIL bp_cnt0 got %0d want %0d", op_cnt0, cnt_m[0]); end
        req_valid = 2'b00; rsp_ready = 1'b0;
    endtask

    task automatic test_opcode_sweep();
        bit seen_b4 = 1'b0;
        rsp_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            @(negedge clk);
            req_a[7:4] = 4'd15; req_b[7:4] = 4'd15; req_op[5:3] = 3'(op);
            req_valid = 2'b10;
            #1;
            tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL sweep_ready%0d got %b want 10", op, req_ready); end
            @(negedge clk);
            req_valid = 2'b00;
            @(negedge clk);
            tests++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== golden(15, 15, op))
                begin fails++; $display("FAIL sweep_op%0d got v=%b id=%b res=%0d want 1/1/%0d", op, rsp_valid, rsp_id, rsp_result, golden(15, 15, op)); end
            seen_b4 |= rsp_result[4];
            model_done(1'b1);
            pri_m = 1'b0;
            @(negedge clk);
        end
        tests++; if (seen_b4 !== 1'b1) begin fails++; $display("FAIL sweep_bit4 got %b want 1", seen_b4); end
        tests++; if (op_cnt1 !== 8'(cnt_m[1])) begin fails++; $display("FAIL sweep_cnt1 got %0d want %0d", op_cnt1, cnt_m[1]); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] v;
        logic [1:0] er;
        bit g;
        int ea;
        int eb;
        int eo;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            v = 2'($urandom_range(0, 3));
            req_a = 8'($urandom); req_b = 8'($urandom); req_op = 6'($urandom);
            req_valid = v; rsp_ready = 1'b0;
            #1;
            er = (v == 2'b11) ? (pri_m ? 2'b10 : 2'b01) : v;
            tests++; if (req_ready !== er) begin fails++; $display("FAIL rand_ready%0d got %b want %b", i, req_ready, er); end
            if (v == 2'b00) continue;
            g = (v == 2'b11) ? pri_m : v[1];
            ea = g ? int'(req_a[7:4]) : int'(req_a[3:0]);
            eb = g ? int'(req_b[7:4]) : int'(req_b[3:0]);
            eo = g ? int'(req_op[5:3]) : int'(req_op[2:0]);
            pri_m = !g;
            @(negedge clk);
            req_a = 8'($urandom); req_b = 8'($urandom); req_op = 6'($urandom);
            req_valid = 2'($urandom_range(0, 3));
            @(negedge clk);
            tests++; if (rsp_valid !== 1'b1 || rsp_id !== g || rsp_result !== golden(ea, eb, eo))
                begin fails++; $display("FAIL rand_rsp%0d got v=%b id=%b res=%0d want 1/%b/%0d", i, rsp_valid, rsp_id, rsp_result, g, golden(ea, eb, eo)); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0; req_valid = 2'b00;
            model_done(g);
            tests++; if (rsp_valid !== 1'b0 || op_cnt0 !== 8'(cnt_m[0]) || op_cnt1 !== 8'(cnt_m[1]))
                begin fails++; $display("FAIL rand_done%0d got v=%b cnt=%0d/%0d want 0/%0d/%0d", i, rsp_valid, op_cnt0, op_cnt1, cnt_m[0], cnt_m[1]); end
        end
    endtask

    task automatic test_reset_mid();
        bit stale;
        for (int ph = 0; ph < 2; ph++) begin
            @(negedge clk);
            req_a[3:0] = 4'($urandom); req_b[3:0] = 4'($urandom); req_op[2:0] = 3'($urandom);
            req_valid = 2'b01; rsp_ready = 1'b0;
            @(negedge clk);
            req_valid = 2'b00;
            if (ph == 1) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            #1;
            tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid%0d_state got v=%b busy=%b want 0/0", ph, rsp_valid, busy); end
            tests++; if (op_cnt0 !== 8'd0 || op_cnt1 !== 8'd0) begin fails++; $display("FAIL rstmid%0d_cnt got %0d/%0d want 0/0", ph, op_cnt0, op_cnt1); end
            rst = 1'b0; rsp_ready = 1'b1;
            cnt_m = '{0, 0};
            pri_m = 1'b0;
            stale = 1'b0;
            repeat (3) begin
                @(negedge clk);
                stale |= rsp_valid;
            end
            tests++; if (stale !== 1'b0) begin fails++; $display("FAIL rstmid%0d_stale got %b want 0", ph, stale); end
            req_valid = 2'b11;
            #1;
            tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL rstmid%0d_rrptr got %b want 01", ph, req_ready); end
            req_valid = 2'b00; rsp_ready = 1'b0;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 258; i++) begin
            @(negedge clk);
            req_a[3:0] = 4'($urandom); req_b[3:0] = 4'($urandom); req_op[2:0] = 3'($urandom);
            req_valid = 2'b01;
            @(negedge clk);
            req_valid = 2'b00;
            @(negedge clk);
            model_done(1'b0);
        end
        @(negedge clk);
        #1;
        tests++; if (op_cnt0 !== 8'(cnt_m[0]) || cnt_m[0] != 255) begin fails++; $display("FAIL sat_cnt0 got %0d want 255", op_cnt0); end
        tests++; if (op_cnt1 !== 8'd0) begin fails++; $display("FAIL sat_cnt1 got %0d want 0", op_cnt1); end
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_opcode_sweep();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
